// File: rtl/spi_pkg.sv
// Shared widths, byte type and pin idle levels for the SPI receive slice.
// Used by spi_byte_rx and spi_rx_fifo.
package spi_pkg;
  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;
endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous byte FIFO with a registered head-of-queue output.
// Push while full is accepted only when a pop happens in the same cycle.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  spi_byte_t                  wdata,
  input  logic                       pop,
  output spi_byte_t                  rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  spi_byte_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Head register follows the entry that becomes head next cycle
      if (do_pop) begin
        if (count == (AW+1)'(1)) begin
          if (do_push) rdata <= wdata;
        end else begin
          rdata <= mem[rd_nxt];
        end
      end else if (do_push && empty) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte receiver: pin sync, edge detect, deserialise, FIFO.
// Optional miso echo of the last received byte under SPI_MISO_ECHO_EN.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_start,
  output logic                  frame_err,
  output logic                  overflow
);

  logic [SYNC_STAGES-1:0]   sclk_sync;
  logic [SYNC_STAGES-1:0]   cs_sync;
  logic [SYNC_STAGES-1:0]   mosi_sync;
  logic [SYNC_STAGES-1:0]   fill;
  logic                     sclk_s;
  logic                     cs_s;
  logic                     mosi_s;
  logic                     sclk_d;
  logic                     cs_d;
  logic                     sclk_rise;
  logic                     cs_fall;
  logic                     cs_rise;
  logic                     armed;
  logic [SPI_BYTE_W-2:0]    shreg;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt;
  spi_byte_t                byte_done;
  logic                     shift_en;
  logic                     push;
  logic                     pop;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // fill marks when the cs chain holds a real pin sample rather than reset idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync   <= {SYNC_STAGES{CS_IDLE}};
      mosi_sync <= {SYNC_STAGES{MOSI_IDLE}};
      fill      <= '0;
      sclk_d    <= SCLK_IDLE;
      cs_d      <= CS_IDLE;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign byte_done   = {shreg, mosi_s};
  assign shift_en    = armed & ~cs_s & sclk_rise & ~cs_fall;
  assign push        = shift_en & (bit_cnt == SPI_BIT_CNT_W'(7));
  assign frame_start = armed & cs_fall;
  assign frame_err   = armed & cs_rise & (bit_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (fill[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
      if (armed && (cs_rise || cs_fall)) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= byte_done[SPI_BYTE_W-2:0];
        bit_cnt <= bit_cnt + SPI_BIT_CNT_W'(1);
      end
    end
  end

  assign pop      = rx_ready & ~fifo_empty;
  assign rx_valid = (fifo_count != '0);

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (byte_done),
    .pop   (pop),
    .rdata (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end

`ifdef SPI_MISO_ECHO_EN
  spi_byte_t last_byte;
  spi_byte_t tx_sh;
  logic      sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_byte <= '0;
      tx_sh     <= '0;
    end else if (armed) begin
      if (push) begin
        last_byte <= byte_done;
        tx_sh     <= byte_done;
      end else if (cs_fall) begin
        tx_sh <= last_byte;
      end else if (sclk_fall && !cs_s) begin
        tx_sh <= {tx_sh[SPI_BYTE_W-2:0], 1'b0};
      end
    end
  end

  assign miso = ~cs_s & tx_sh[SPI_BYTE_W-1];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Scoreboard bench for spi_byte_rx: bytes expected on the handshake are queued
// when a frame is driven and compared as the DUT hands them out.
module tb_spi_byte_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_start;
  logic       frame_err;
  logic       overflow;

  int         n_checks = 0;
  int         n_fails  = 0;
  int         fs_cnt   = 0;
  int         fe_cnt   = 0;
  int         pop_cnt  = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  spi_byte_rx #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_start (frame_start),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_cnt++;
      if (frame_err) fe_cnt++;
      if (rx_valid && rx_ready) begin
        pop_cnt++;
        check("pop_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #62 sclk = 1'b1;
      #62 sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b);
    cs = 1'b0;
    #124;
    bits(b, 8);
    #124;
    cs = 1'b1;
    #200;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("valid_after_drain", rx_valid, 0);
  endtask

  int         fs0, fe0, p0;
  logic [7:0] echo_exp;

  initial begin
    rst      = 1'b1;
    sclk     = 1'b0;
    cs       = 1'b1;
    mosi     = 1'b0;
    rx_ready = 1'b0;
    #35;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fs", frame_start, 0);
    check("rst_fe", frame_err, 0);
    check("rst_miso", miso, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // single byte with ready high
    set_ready(1'b1);
    fs0 = fs_cnt; fe0 = fe_cnt; p0 = pop_cnt;
    exp_q.push_back(8'hAA);
    frame(8'hAA);
    drain();
    check("t1_fs", fs_cnt - fs0, 1);
    check("t1_fe", fe_cnt - fe0, 0);
    check("t1_pops", pop_cnt - p0, 1);

    // three frames buffered, then drained in order
    set_ready(1'b0);
    p0 = pop_cnt;
    exp_q.push_back(8'h33); frame(8'h33);
    exp_q.push_back(8'hFF); frame(8'hFF);
    exp_q.push_back(8'h00); frame(8'h00);
    #1 check("t2_valid", rx_valid, 1);
    check("t2_head", rx_data, 8'h33);
    check("t2_pops_held", pop_cnt - p0, 0);
    set_ready(1'b1);
    drain();
    check("t2_pops", pop_cnt - p0, 3);
    check("t2_ovf", overflow, 0);

    // sclk toggling with cs high is ignored
    fs0 = fs_cnt; p0 = pop_cnt;
    bits(8'hAA, 8);
    #300;
    check("t3_fs", fs_cnt - fs0, 0);
    check("t3_pops", pop_cnt - p0, 0);
    check("t3_valid", rx_valid, 0);

    // aborted partial byte then a clean frame
    fe0 = fe_cnt; p0 = pop_cnt;
    cs = 1'b0;
    #124;
    bits(8'hF0, 5);
    #124;
    cs = 1'b1;
    #200;
    check("t4_fe", fe_cnt - fe0, 1);
    check("t4_pops_partial", pop_cnt - p0, 0);
    exp_q.push_back(8'h5A);
    frame(8'h5A);
    drain();
    check("t4_fe_total", fe_cnt - fe0, 1);
    check("t4_pops", pop_cnt - p0, 1);

    // overflow on the fifth byte into a 4-deep FIFO
    set_ready(1'b0);
    p0 = pop_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      frame(8'(i));
    end
    check("t5_ovf", overflow, 1);
    check("t5_head", rx_data, 8'h01);
    check("t5_valid", rx_valid, 1);
    set_ready(1'b1);
    drain();
    check("t5_pops", pop_cnt - p0, 4);
    check("t5_ovf_sticky", overflow, 1);

    // miso echo of the previous byte across the next frame
    exp_q.push_back(8'hC3);
    frame(8'hC3);
    check("t6_miso_idle", miso, 0);
    exp_q.push_back(8'h00);
`ifdef SPI_MISO_ECHO_EN
    echo_exp = 8'hC3;
`else
    echo_exp = 8'h00;
`endif
    cs = 1'b0;
    #124;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b0;
      #62 sclk = 1'b1;
      #31 check($sformatf("t6_miso_b%0d", i), miso, echo_exp[7-i]);
      #31 sclk = 1'b0;
    end
    #124;
    cs = 1'b1;
    #200;
    drain();
    check("t6_miso_end", miso, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
